// File: rtl/ddr_pkt_pkg.sv
// ddr_pkt_pkg: shared types and constants for the DDR packet read scheduler.
//   BEAT_BYTES     : default bytes per AXI data beat (512-bit bus)
//   AXI_BURST_INCR : AXI AxBURST encoding for incrementing bursts
//   DESC_ADDR_W    : address field width of a queued descriptor (wide enough
//                    for any supported ADDR_WIDTH; unused upper bits are zero)
//   state_t        : scheduler FSM states
//   desc_t         : packet descriptor {addr, len}
package ddr_pkt_pkg;

    localparam int         BEAT_BYTES     = 64;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         DESC_ADDR_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [15:0]            len;
    } desc_t;

endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: synchronous show-ahead FIFO of packet descriptors.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write request, ignored while full
//   push_data  : descriptor to write
//   full       : no free entry
//   pop        : read request, ignored while empty
//   head       : oldest entry (valid while count != 0)
//   count      : number of stored entries, 0..DEPTH
module desc_fifo
    import ddr_pkt_pkg::*;
#(
    parameter int DEPTH = 16   // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  desc_t                    push_data,
    output logic                     full,
    input  logic                     pop,
    output desc_t                    head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    desc_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; validity is carried
    // by the pointers and count, and a reset on the array would block RAM mapping.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_sched.sv
// ddr_rd_sched: turns queued packet descriptors into AXI4 read bursts and
// forwards the returned data as an AXI-Stream packet.
//   clk, rst          : clock, synchronous active-high reset
//   rd_en             : level enable for starting new packets
//   desc_*            : descriptor input (valid/ready, byte address, byte length)
//   m_axi_ar*         : read address channel (one burst outstanding at most)
//   m_axi_r*          : read data channel, passed straight through in DATA
//   m_axis_t*         : packet stream; tlast/tkeep mark the packet tail
//   desc_cnt          : descriptors waiting in the queue
//   pkt_cnt           : packets fully emitted (wraps)
module ddr_rd_sched
    import ddr_pkt_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = BEAT_BYTES * 8,
    parameter int DESC_DEPTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_en,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [ADDR_WIDTH-1:0]          desc_addr,
    input  logic [15:0]                    desc_len,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
    output logic [$clog2(DESC_DEPTH):0]    desc_cnt,
    output logic [31:0]                    pkt_cnt
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LOG2B  = $clog2(BYTES);
    localparam int TAIL_W = (LOG2B > 0) ? LOG2B : 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;     // beat-aligned address of the next burst
    logic [16:0]             beats_q;    // beats of the packet not yet requested
    logic [TAIL_W-1:0]       tail_q;     // len mod BYTES, sizes the final tkeep
    desc_t                   desc_in;
    desc_t                   head;
    logic                    fifo_full;
    logic                    pop;
    logic                    load;
    logic                    advance;
    logic                    pkt_done;
    logic                    in_data;
    logic                    beat_hs;
    logic                    last_burst;
    logic [11:0]             page_off;
    logic [16:0]             to_page;
    logic [16:0]             burst;
    logic                    unused_addr_hi;

    assign desc_in        = '{addr: DESC_ADDR_W'(desc_addr), len: desc_len};
    assign unused_addr_hi = ^head.addr[DESC_ADDR_W-1:ADDR_WIDTH];

    desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (desc_valid && desc_ready),
        .push_data (desc_in),
        .full      (fifo_full),
        .pop       (pop),
        .head      (head),
        .count     (desc_cnt)
    );

    assign desc_ready = !rst && !fifo_full;

    // Burst size: the smallest of what is left, the burst cap, and the beats
    // that fit before the next 4 KB page. addr_q and beats_q only change on
    // load/advance, so araddr/arlen hold steady while arvalid waits.
    assign page_off = 12'(addr_q);
    assign to_page  = 17'((13'd4096 - {1'b0, page_off}) >> LOG2B);

    always_comb begin
        burst = beats_q;
        if (burst > 17'(MAX_BURST)) burst = 17'(MAX_BURST);
        if (burst > to_page)        burst = to_page;
    end

    assign last_burst = (beats_q == burst);

    // Outputs are gated by rst so they read inactive for the whole reset,
    // including the first cycle before the state register has been cleared.
    assign in_data       = (state_q == DATA) && !rst;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(burst - 17'd1);
    assign m_axi_arsize  = 3'(LOG2B);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = (state_q == ADDR) && !rst;
    assign m_axi_rready  = in_data && m_axis_tready;
    assign m_axis_tvalid = in_data && m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = m_axis_tvalid && m_axi_rlast && last_burst;
    assign beat_hs       = m_axis_tvalid && m_axis_tready;

    always_comb begin
        m_axis_tkeep = '1;
        if (m_axis_tlast && (tail_q != '0)) begin
            m_axis_tkeep = {BYTES{1'b1}} >> (BYTES - int'(tail_q));
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        pkt_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_en && (desc_cnt != '0)) begin
                    pop = 1'b1;
                    // Zero-length descriptors are consumed without any traffic.
                    if (head.len != 16'd0) begin
                        load    = 1'b1;
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (m_axi_arready) state_d = DATA;
            end
            DATA: begin
                if (beat_hs && m_axi_rlast) begin
                    if (last_burst) begin
                        pkt_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            beats_q <= '0;
            tail_q  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (load) begin
                addr_q  <= ADDR_WIDTH'(head.addr) & ~ADDR_WIDTH'(BYTES - 1);
                beats_q <= ({1'b0, head.len} + 17'(BYTES - 1)) >> LOG2B;
                tail_q  <= TAIL_W'(head.len & 16'(BYTES - 1));
            end else if (advance) begin
                addr_q  <= addr_q + (ADDR_WIDTH'(burst) << LOG2B);
                beats_q <= beats_q - burst;
            end
            if (pkt_done) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ddr_rd_sched.sv
// tb_ddr_rd_sched: scoreboard bench. Descriptor pushes feed a reference model
// that queues the expected AR bursts and stream beats; independent monitors
// pop and compare whenever the DUT presents an AR handshake or a stream beat.
// A behavioural DDR slave answers each AR with address-derived data.
module tb_ddr_rd_sched;

    localparam int AW    = 16;
    localparam int DW    = 512;
    localparam int BB    = DW / 8;
    localparam int DEPTH = 16;
    localparam int MAXB  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd_en = 1'b0;
    logic            desc_valid = 1'b0;
    logic            desc_ready;
    logic [AW-1:0]   desc_addr = '0;
    logic [15:0]     desc_len = '0;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [DW-1:0]   m_axi_rdata = '0;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic            m_axis_tlast;
    logic [BB-1:0]   m_axis_tkeep;
    logic [4:0]      desc_cnt;
    logic [31:0]     pkt_cnt;

    always #5 clk = ~clk;

    ddr_rd_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DESC_DEPTH (DEPTH),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_addr     (desc_addr),
        .desc_len      (desc_len),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .desc_cnt      (desc_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    typedef struct { logic [15:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic last; logic [BB-1:0] keep; } beat_t;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    ar_t   ddr_q[$];
    ar_t   ar_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pkts = 0;
    int pkts_seen = 0;
    int beats_seen = 0;
    int ar_hs = 0;
    bit outstanding = 1'b0;
    bit stall_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory content is a pure function of the beat address.
    function automatic logic [DW-1:0] pat(input logic [15:0] a);
        logic [DW-1:0] p;
        for (int k = 0; k < DW / 32; k++) begin
            p[k*32 +: 32] = {a, 16'(k * 16'h1357) ^ ~a};
        end
        return p;
    endfunction

    // Reference model: split the packet into bursts by the three limits and
    // list every beat the stream must carry.
    function automatic void model_push(input logic [15:0] addr, input int len);
        logic [15:0] base;
        logic [15:0] a;
        int beats, rem, to4k, b;
        beat_t t;
        if (len == 0) return;
        exp_pkts++;
        base  = addr & 16'hFFC0;
        a     = base;
        beats = (len + BB - 1) / BB;
        rem   = beats;
        while (rem > 0) begin
            to4k = (4096 - (int'(a) % 4096)) / BB;
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > to4k) b = to4k;
            exp_ar_q.push_back('{addr: a, len: 8'(b - 1)});
            a   = a + 16'(b * BB);
            rem = rem - b;
        end
        for (int i = 0; i < beats; i++) begin
            t.data = pat(base + 16'(i * BB));
            t.last = (i == beats - 1);
            if (t.last && (len % BB) != 0) t.keep = (64'd1 << (len % BB)) - 64'd1;
            else                           t.keep = '1;
            exp_beat_q.push_back(t);
        end
    endfunction

    // AR slave + monitor.
    initial begin : ar_proc
        bit          pend = 1'b0;
        logic [15:0] pend_addr;
        logic [7:0]  pend_len;
        ar_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_arready = 1'b0;
                pend = 1'b0;
                continue;
            end
            m_axi_arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
            #4;
            if (pend) begin
                check("ar_hold_valid", m_axi_arvalid, 1'b1);
                check("ar_hold_addr", m_axi_araddr, pend_addr);
                check("ar_hold_len", m_axi_arlen, pend_len);
            end
            pend = m_axi_arvalid && !m_axi_arready;
            pend_addr = m_axi_araddr;
            pend_len  = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs++;
                check("ar_single_outstanding", outstanding, 1'b0);
                outstanding = 1'b1;
                ddr_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
                ar_log.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
                check("arsize", m_axi_arsize, 3'd6);
                check("arburst", m_axi_arburst, 2'b01);
                if (exp_ar_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ar: got addr %0h len %0d expected none", m_axi_araddr, m_axi_arlen);
                end else begin
                    e = exp_ar_q.pop_front();
                    check("araddr", m_axi_araddr, e.addr);
                    check("arlen", m_axi_arlen, e.len);
                end
            end
        end
    end

    // R slave: one burst at a time, random gaps; stray rvalid while idle.
    initial begin : r_proc
        bit  busy = 1'b0;
        int  idx = 0;
        ar_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                ddr_q.delete();
                busy = 1'b0;
                m_axi_rvalid = 1'b0;
                m_axi_rlast = 1'b0;
                continue;
            end
            if (!busy && ddr_q.size() > 0) begin
                b = ddr_q.pop_front();
                busy = 1'b1;
                idx = 0;
            end
            if (busy) begin
                m_axi_rvalid = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_axi_rdata  = pat(b.addr + 16'(idx * BB));
                m_axi_rlast  = (idx == int'(b.len));
            end else begin
                m_axi_rvalid = ($urandom_range(0, 7) == 0);
                m_axi_rdata  = {16{$urandom()}};
                m_axi_rlast  = $urandom_range(0, 1) == 1;
            end
            #4;
            if (busy && m_axi_rvalid && m_axi_rready) begin
                idx++;
                if (m_axi_rlast) begin
                    busy = 1'b0;
                    outstanding = 1'b0;
                end
            end else if (!busy && m_axi_rvalid) begin
                check("rready_outside_data", m_axi_rready, 1'b0);
                check("tvalid_outside_data", m_axis_tvalid, 1'b0);
            end
        end
    end

    // Stream sink + scoreboard monitor.
    initial begin : s_proc
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axis_tready = 1'b0;
                continue;
            end
            m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            #4;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                if (m_axis_tlast) pkts_seen++;
                if (exp_beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tlast %0b expected no beat", m_axis_tlast);
                end else begin
                    e = exp_beat_q.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tlast", m_axis_tlast, e.last);
                    check("tkeep", m_axis_tkeep, e.keep);
                end
            end
        end
    end

    initial begin : watchdog
        #(600000);
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        rd_en = 1'b0;
        desc_valid = 1'b0;
        repeat (n) @(negedge clk);
        exp_ar_q.delete();
        exp_beat_q.delete();
        exp_pkts = 0;
        pkts_seen = 0;
        outstanding = 1'b0;
        #1;
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_rready", m_axi_rready, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_desc_ready", desc_ready, 1'b0);
        check("rst_desc_cnt", desc_cnt, 5'd0);
        check("rst_pkt_cnt", pkt_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_desc_ready", desc_ready, 1'b1);
    endtask

    task automatic try_push(input logic [15:0] a, input int len, input int bound, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            desc_valid = 1'b1;
            desc_addr  = a;
            desc_len   = 16'(len);
            #4;
            if (desc_ready) begin
                acc = 1'b1;
                model_push(a, len);
                @(posedge clk);
                #1;
                desc_valid = 1'b0;
                return;
            end
        end
        desc_valid = 1'b0;
    endtask

    task automatic push_desc(input logic [15:0] a, input int len);
        bit acc;
        try_push(a, len, 2000, acc);
        check("desc_accept", acc, 1'b1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            done = (pkts_seen == exp_pkts) && (exp_beat_q.size() == 0) && (exp_ar_q.size() == 0);
        end
        repeat (2) @(negedge clk);
        #1;
        check("drain", done, 1'b1);
        check("pkt_cnt", pkt_cnt, 32'(exp_pkts));
    endtask

    task automatic wait_beats(input int target);
        int i = 0;
        while (beats_seen < target && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check("beat_wait", beats_seen >= target, 1'b1);
    endtask

    initial begin : main
        int a0, b0, p0, n0;
        bit acc;
        logic [15:0] ra;
        int rl, kind;

        do_reset(3);
        rd_en = 1'b1;

        // Single short packet: one beat, 46 bytes kept.
        a0 = ar_log.size(); b0 = beats_seen;
        push_desc(16'h0000, 46);
        wait_drain();
        check("t1_ar_count", ar_log.size() - a0, 1);
        check("t1_arlen", ar_log[a0].len, 8'd0);
        check("t1_beats", beats_seen - b0, 19'd1);
        check("t1_pkt_cnt", pkt_cnt, 32'd1);

        // 1200 bytes: bursts of 16 and 3 beats.
        a0 = ar_log.size(); b0 = beats_seen;
        push_desc(16'h0000, 1200);
        wait_drain();
        check("t2_ar_count", ar_log.size() - a0, 2);
        check("t2_addr0", ar_log[a0].addr, 16'h0000);
        check("t2_len0", ar_log[a0].len, 8'd15);
        check("t2_addr1", ar_log[a0+1].addr, 16'h0400);
        check("t2_len1", ar_log[a0+1].len, 8'd2);
        check("t2_beats", beats_seen - b0, 19);

        // 4 KB split.
        a0 = ar_log.size(); p0 = pkts_seen;
        push_desc(16'h0F80, 256);
        wait_drain();
        check("t3_ar_count", ar_log.size() - a0, 2);
        check("t3_addr0", ar_log[a0].addr, 16'h0F80);
        check("t3_len0", ar_log[a0].len, 8'd1);
        check("t3_addr1", ar_log[a0+1].addr, 16'h1000);
        check("t3_len1", ar_log[a0+1].len, 8'd1);
        check("t3_one_tlast", pkts_seen - p0, 1);

        // Zero-length descriptor is dropped; unaligned address low bits ignored.
        a0 = ar_log.size(); p0 = pkts_seen;
        push_desc(16'h0100, 0);
        push_desc(16'h0155, 64);
        wait_drain();
        check("t4_ar_count", ar_log.size() - a0, 1);
        check("t4_addr", ar_log[a0].addr, 16'h0140);
        check("t4_pkts", pkts_seen - p0, 1);

        // Queue fill with rd_en low, then release.
        do_reset(2);
        a0 = ar_log.size();
        for (int i = 0; i < DEPTH; i++) push_desc(16'(i * 16'h0400), 40 + i * 70);
        check("full_desc_cnt", desc_cnt, 5'd16);
        check("full_desc_ready", desc_ready, 1'b0);
        try_push(16'hA000, 100, 10, acc);
        check("full_reject", acc, 1'b0);
        repeat (5) @(negedge clk);
        check("no_ar_when_disabled", ar_log.size() - a0, 0);
        @(negedge clk);
        rd_en = 1'b1;
        wait_drain();
        check("t5_pkt_cnt", pkt_cnt, 32'd16);

        // rd_en dropped mid-packet.
        a0 = ar_log.size(); p0 = pkts_seen; b0 = beats_seen;
        push_desc(16'h2000, 800);
        wait_beats(b0 + 3);
        @(negedge clk);
        rd_en = 1'b0;
        push_desc(16'h3000, 128);
        n0 = 0;
        while (pkts_seen < p0 + 1 && n0 < 2000) begin
            @(negedge clk);
            n0++;
        end
        check("t6_first_done", pkts_seen - p0, 1);
        check("t6_beats", beats_seen - b0, 13);
        repeat (30) @(negedge clk);
        #1;
        check("t6_no_new_ar", ar_log.size() - a0, 1);
        check("t6_desc_cnt", desc_cnt, 5'd1);
        @(negedge clk);
        rd_en = 1'b1;
        wait_drain();

        // Randomized mix with stalls on every channel.
        stall_en = 1'b1;
        for (int p = 0; p < 50; p++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      rl = 0;
            else if (kind < 3)  rl = $urandom_range(1, 64);
            else if (kind < 5)  rl = 64 * $urandom_range(1, 40);
            else                rl = $urandom_range(1, 3000);
            if ($urandom_range(0, 2) == 0)
                ra = 16'($urandom_range(0, 13) * 4096 + 4096 - $urandom_range(1, 8) * 64 + $urandom_range(0, 63));
            else
                ra = 16'($urandom_range(0, 16'hDFFF));
            push_desc(ra, rl);
        end
        wait_drain();
        stall_en = 1'b0;

        // Reset in the middle of a packet, then reuse.
        b0 = beats_seen;
        push_desc(16'h0000, 3000);
        wait_beats(b0 + 5);
        do_reset(3);
        rd_en = 1'b1;
        push_desc(16'h0040, 100);
        wait_drain();
        check("t8_pkt_cnt", pkt_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_rd_sched.md
DDR_RD_SCHED -- requirements
Module: ddr_rd_sched

Interface
REQ-001 Parameters SHALL be:
  ADDR_WIDTH, default 16, AXI byte-address width.
  DATA_WIDTH, default 512, beat width; BEAT_BYTES = DATA_WIDTH/8.
  DESC_DEPTH, default 16, descriptor queue depth, power of 2.
  MAX_BURST, default 16, maximum beats per AR burst, 1..256.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  rd_en  in  1  level-sensitive; 1 permits new packet reads.
  desc_valid  in  1  descriptor offered.
  desc_ready  out  1  queue not full.
  desc_addr  in  ADDR_WIDTH  packet start byte address, beat-aligned.
  desc_len  in  16  packet length in bytes.
  m_axi_araddr  out  ADDR_WIDTH  burst address.
  m_axi_arlen  out  8  beats-1.
  m_axi_arsize  out  3  constant log2(BEAT_BYTES).
  m_axi_arburst  out  2  constant 2'b01 (INCR).
  m_axi_arvalid  out  1  AR request.
  m_axi_arready  in  1  AR accept.
  m_axi_rdata  in  DATA_WIDTH  read data.
  m_axi_rlast  in  1  last beat of burst.
  m_axi_rvalid  in  1  read data valid.
  m_axi_rready  out  1  read data accept.
  m_axis_tdata  out  DATA_WIDTH  packet data.
  m_axis_tvalid  out  1  stream valid.
  m_axis_tready  in  1  stream accept.
  m_axis_tlast  out  1  last beat of packet.
  m_axis_tkeep  out  BEAT_BYTES  byte enables.
  desc_cnt  out  $clog2(DESC_DEPTH)+1  queued descriptors.
  pkt_cnt  out  32  packets fully emitted, wraps.

Function
REQ-003 A descriptor SHALL be enqueued on the clk edge where desc_valid && desc_ready.
REQ-004 desc_ready SHALL be 0 when desc_cnt == DESC_DEPTH; a simultaneous enqueue and dequeue SHALL leave desc_cnt unchanged.
REQ-005 The FSM SHALL use the states IDLE, ADDR and DATA.
REQ-006 IDLE -> ADDR SHALL occur when rd_en && desc_cnt != 0: pop the descriptor and load total beats = ceil(len/BEAT_BYTES).
REQ-007 A descriptor with len == 0 SHALL be popped and discarded, with no AXI traffic and no pkt_cnt increment.
REQ-008 Burst beats SHALL equal min(remaining beats, MAX_BURST, beats to the next 4 KB boundary); arlen SHALL equal beats-1.
REQ-009 In ADDR, arvalid SHALL be 1 with stable araddr/arlen until arready; ADDR -> DATA SHALL occur on the handshake.
REQ-010 At most one AR burst SHALL be outstanding.
REQ-011 In DATA, m_axis_tdata/tvalid SHALL combinationally mirror rdata/rvalid; rready SHALL equal m_axis_tready; zero added latency.
REQ-012 On a beat with rlast: if beats remain, the address SHALL advance by burst*BEAT_BYTES and the FSM SHALL go to ADDR; otherwise it SHALL go to IDLE and pkt_cnt SHALL increment.
REQ-013 tlast SHALL be 1 only on the final beat of the final burst of a packet.
REQ-014 tkeep SHALL be all ones except on the tlast beat, where it SHALL be the low (len mod BEAT_BYTES) bits set, or all ones if that value is 0.
REQ-015 Deasserting rd_en mid-packet SHALL NOT abort the packet; it SHALL only block the next IDLE -> ADDR transition.
REQ-016 Low address bits below log2(BEAT_BYTES) SHALL be ignored and driven to 0 on araddr.
REQ-017 rvalid outside DATA SHALL be ignored, with rready = 0.

Reset
REQ-018 While rst is asserted: FSM = IDLE; queue empty; desc_cnt = 0; pkt_cnt = 0; arvalid, rready, m_axis_tvalid, m_axis_tlast = 0; desc_ready = 0.
REQ-019 desc_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-020 Reset mid-packet SHALL abandon the packet and flush the queue; the bench drains the DDR model before reuse.

Structure
REQ-021 Package ddr_pkt_pkg SHALL hold BEAT_BYTES, AXI_BURST_INCR, the FSM state enum and the descriptor struct {addr, len}.
REQ-022 The queue SHALL be sub-module desc_fifo: synchronous FIFO, DESC_DEPTH entries, with a count output.

Verification
REQ-023 rd_en=1; one descriptor (0x0000, 46) -> one AR with arlen=0; one beat with tlast=1, tkeep=46 low ones; pkt_cnt=1.
REQ-024 Descriptor (0x0000, 1200) with MAX_BURST=16 -> ARs with arlen 15 then 2 at 0x0000 and 0x0400; 19 beats; tkeep on the last beat = 48 ones.
REQ-025 Descriptor (0x0F80, 256) -> two bursts of 2 beats at 0x0F80 and 0x1000 (4 KB split); a single tlast.
REQ-026 rd_en=0 with 17 descriptors pushed -> desc_ready low after 16; no AR; then rd_en=1 -> 16 packets emitted in order; pkt_cnt=16.
REQ-027 Random m_axis_tready and arready stalls over 50 mixed-length packets -> no data loss; beat count per packet = ceil(len/64); no AR issued while a burst is in flight.
REQ-028 rd_en dropped mid-burst on an 800-byte packet -> all 13 beats complete; no new AR until rd_en returns.
